// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default VGA timing constants and counter widths shared with the pixel pipeline
package vga_timing_pkg;

  localparam int H_W     = 11;
  localparam int V_W     = 10;
  localparam int FRAME_W = 11;

  localparam int H_DISPLAY_DEF     = 1220;
  localparam int H_FRONT_PORCH_DEF = 31;
  localparam int H_SYNC_PULSE_DEF  = 183;
  localparam int H_TOTAL_DEF       = 1525;

  localparam int V_DISPLAY_DEF     = 480;
  localparam int V_FRONT_PORCH_DEF = 10;
  localparam int V_SYNC_PULSE_DEF  = 2;
  localparam int V_TOTAL_DEF       = 525;

  localparam int PRE_LEAD_DEF      = 16;

  // Wide enough for any position or window bound of either axis.
  typedef logic [15:0] pos_t;

  function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_timing_wrap_counter.sv
// rtl/vga_timing_wrap_counter.sv - modulo counter that advances on ce and flags its last count
module wrap_counter #(
  parameter int WIDTH   = 11,
  parameter int MODULUS = 1525
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (ce) begin
      count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = ce && (count_q == LAST);

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - VGA raster counters, per-line strobes and registered syncs/de gated by a pixel enable
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY     = H_DISPLAY_DEF,
  parameter int H_FRONT_PORCH = H_FRONT_PORCH_DEF,
  parameter int H_SYNC_PULSE  = H_SYNC_PULSE_DEF,
  parameter int H_TOTAL       = H_TOTAL_DEF,
  parameter int V_DISPLAY     = V_DISPLAY_DEF,
  parameter int V_FRONT_PORCH = V_FRONT_PORCH_DEF,
  parameter int V_SYNC_PULSE  = V_SYNC_PULSE_DEF,
  parameter int V_TOTAL       = V_TOTAL_DEF,
  parameter int PRE_LEAD      = PRE_LEAD_DEF
) (
  input  logic               clk48,
  input  logic               rst,
  input  logic               ce,
  output logic [H_W-1:0]     h_count,
  output logic [V_W-1:0]     v_count,
  output logic [FRAME_W-1:0] frame,
  output logic               visible,
  output logic               pre_hblank,
  output logic               hblank_start,
  output logic               line_end,
  output logic               frame_end,
  output logic               hsync,
  output logic               vsync,
  output logic               de
);

  localparam logic [H_W-1:0] H_PRE = H_W'(H_DISPLAY - PRE_LEAD);
  localparam logic [H_W-1:0] H_VIS = H_W'(H_DISPLAY);
  localparam logic [V_W-1:0] V_VIS = V_W'(V_DISPLAY);
  localparam pos_t HS_LO = pos_t'(H_DISPLAY + H_FRONT_PORCH);
  localparam pos_t HS_HI = pos_t'(H_DISPLAY + H_FRONT_PORCH + H_SYNC_PULSE);
  localparam pos_t VS_LO = pos_t'(V_DISPLAY + V_FRONT_PORCH);
  localparam pos_t VS_HI = pos_t'(V_DISPLAY + V_FRONT_PORCH + V_SYNC_PULSE);

  logic               h_wrap;
  logic               v_wrap;
  logic               qual;
  logic               hsync_q;
  logic               hsync_d;
  logic               vsync_q;
  logic               vsync_d;
  logic               de_q;
  logic               de_d;
  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;

  wrap_counter #(
    .WIDTH  (H_W),
    .MODULUS(H_TOTAL)
  ) u_h_counter (
    .clk  (clk48),
    .rst  (rst),
    .ce   (ce),
    .count(h_count),
    .wrap (h_wrap)
  );

  // The vertical counter steps only on the last pixel of each line.
  wrap_counter #(
    .WIDTH  (V_W),
    .MODULUS(V_TOTAL)
  ) u_v_counter (
    .clk  (clk48),
    .rst  (rst),
    .ce   (h_wrap),
    .count(v_count),
    .wrap (v_wrap)
  );

  assign qual    = ce & ~rst;
  assign visible = (h_count < H_VIS) && (v_count < V_VIS);

  // Strobes are decoded straight off the counters so consumers see them with zero latency.
  assign pre_hblank   = qual && (h_count == H_PRE);
  assign hblank_start = qual && (h_count == H_VIS);
  assign line_end     = ~rst & h_wrap;
  assign frame_end    = ~rst & v_wrap;

  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    frame_d = frame_q;
    if (ce) begin
      hsync_d = ~in_window(pos_t'(h_count), HS_LO, HS_HI);
      vsync_d = ~in_window(pos_t'(v_count), VS_LO, VS_HI);
      de_d    = visible;
    end
    if (v_wrap) begin
      frame_d = frame_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      de_q    <= 1'b0;
      frame_q <= '0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      frame_q <= frame_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign de    = de_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - checks a default-size and a tiny-raster vga_timing against an arithmetic raster model
module tb_vga_timing;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic [10:0] f;
    logic        vis;
    logic        pre;
    logic        hbs;
    logic        le;
    logic        fe;
    logic        hs;
    logic        vs;
    logic        de;
  } outs_t;

  typedef struct {
    longint t;
    int     h;
    int     v;
    bit     pre;
    bit     hbs;
    bit     le;
    bit     hs;
  } vec_t;

  // Index 0: default raster, index 1: tiny raster.
  localparam int HT_A  [2] = '{1525, 8};
  localparam int HD_A  [2] = '{1220, 4};
  localparam int HFP_A [2] = '{31, 1};
  localparam int HSP_A [2] = '{183, 1};
  localparam int PL_A  [2] = '{16, 1};
  localparam int VT_A  [2] = '{525, 4};
  localparam int VD_A  [2] = '{480, 2};
  localparam int VFP_A [2] = '{10, 1};
  localparam int VSP_A [2] = '{2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, ce0, ce1;
  logic [10:0] h0, h1, f0, f1;
  logic [9:0]  v0, v1;
  logic vis0, pre0, hbs0, le0, fe0, hs0, vs0, de0;
  logic vis1, pre1, hbs1, le1, fe1, hs1, vs1, de1;
  outs_t o0, o1;

  assign o0 = {h0, v0, f0, vis0, pre0, hbs0, le0, fe0, hs0, vs0, de0};
  assign o1 = {h1, v1, f1, vis1, pre1, hbs1, le1, fe1, hs1, vs1, de1};

  vga_timing u_dut_def (
    .clk48(clk), .rst(rst0), .ce(ce0),
    .h_count(h0), .v_count(v0), .frame(f0), .visible(vis0),
    .pre_hblank(pre0), .hblank_start(hbs0), .line_end(le0), .frame_end(fe0),
    .hsync(hs0), .vsync(vs0), .de(de0)
  );

  vga_timing #(
    .H_DISPLAY(4), .H_FRONT_PORCH(1), .H_SYNC_PULSE(1), .H_TOTAL(8),
    .V_DISPLAY(2), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_TOTAL(4),
    .PRE_LEAD(1)
  ) u_dut_small (
    .clk48(clk), .rst(rst1), .ce(ce1),
    .h_count(h1), .v_count(v1), .frame(f1), .visible(vis1),
    .pre_hblank(pre1), .hblank_start(hbs1), .line_end(le1), .frame_end(fe1),
    .hsync(hs1), .vsync(vs1), .de(de1)
  );

  int     checks = 0;
  int     errors = 0;
  longint t_m [2];
  bit     ehs [2];
  bit     evs [2];
  bit     ede [2];
  int     hs_low = 0;
  int     bad_strobe = 0;
  int     fe_cnt = 0;
  longint cyc_n = 0;
  longint le_at [$];
  outs_t  last0;
  longint last_t0 = -1;
  vec_t   vt [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Raster position is pure arithmetic on the number of enabled clocks since reset.
  function automatic outs_t expect_outs(input int k);
    outs_t  e;
    longint t;
    int     h, v, f;
    bit     r, c, en;
    r  = (k == 0) ? rst0 : rst1;
    c  = (k == 0) ? ce0 : ce1;
    t  = r ? 0 : t_m[k];
    h  = int'(t % HT_A[k]);
    v  = int'((t / HT_A[k]) % VT_A[k]);
    f  = int'((t / (HT_A[k] * VT_A[k])) % 2048);
    en = c && !r;
    e.h   = 11'(h);
    e.v   = 10'(v);
    e.f   = 11'(f);
    e.vis = (h < HD_A[k]) && (v < VD_A[k]);
    e.pre = en && (h == HD_A[k] - PL_A[k]);
    e.hbs = en && (h == HD_A[k]);
    e.le  = en && (h == HT_A[k] - 1);
    e.fe  = e.le && (v == VT_A[k] - 1);
    e.hs  = r ? 1'b1 : ehs[k];
    e.vs  = r ? 1'b1 : evs[k];
    e.de  = r ? 1'b0 : ede[k];
    return e;
  endfunction

  task automatic upd(input int k);
    bit r, c;
    int h, v, hlo, vlo;
    r = (k == 0) ? rst0 : rst1;
    c = (k == 0) ? ce0 : ce1;
    if (r) begin
      t_m[k] = 0; ehs[k] = 1'b1; evs[k] = 1'b1; ede[k] = 1'b0;
    end else if (c) begin
      h   = int'(t_m[k] % HT_A[k]);
      v   = int'((t_m[k] / HT_A[k]) % VT_A[k]);
      hlo = HD_A[k] + HFP_A[k];
      vlo = VD_A[k] + VFP_A[k];
      ehs[k] = !(h >= hlo && h < hlo + HSP_A[k]);
      evs[k] = !(v >= vlo && v < vlo + VSP_A[k]);
      ede[k] = (h < HD_A[k]) && (v < VD_A[k]);
      t_m[k]++;
    end
  endtask

  task automatic check_dut(input int k);
    outs_t a, e;
    string p;
    a = (k == 0) ? o0 : o1;
    e = expect_outs(k);
    p = (k == 0) ? "def" : "small";
    chk({p, ".h_count"}, 64'(a.h), 64'(e.h));
    chk({p, ".v_count"}, 64'(a.v), 64'(e.v));
    chk({p, ".frame"}, 64'(a.f), 64'(e.f));
    chk({p, ".visible"}, 64'(a.vis), 64'(e.vis));
    chk({p, ".pre_hblank"}, 64'(a.pre), 64'(e.pre));
    chk({p, ".hblank_start"}, 64'(a.hbs), 64'(e.hbs));
    chk({p, ".line_end"}, 64'(a.le), 64'(e.le));
    chk({p, ".frame_end"}, 64'(a.fe), 64'(e.fe));
    chk({p, ".hsync"}, 64'(a.hs), 64'(e.hs));
    chk({p, ".vsync"}, 64'(a.vs), 64'(e.vs));
    chk({p, ".de"}, 64'(a.de), 64'(e.de));
  endtask

  // One clock: drive at the falling edge, sample just before the rising edge, advance the model on it.
  task automatic cyc(input bit c0, input bit c1);
    ce0 = c0;
    ce1 = c1;
    #4;
    check_dut(0);
    check_dut(1);
    last0   = o0;
    last_t0 = rst0 ? -1 : t_m[0];
    if (!rst0 && o0.hs == 1'b0 && t_m[0] < 1525) hs_low++;
    if (!c0 && (o0.pre || o0.hbs || o0.le || o0.fe)) bad_strobe++;
    if (o0.le) le_at.push_back(cyc_n);
    if (o1.fe) fe_cnt++;
    cyc_n++;
    @(posedge clk);
    upd(0);
    upd(1);
    @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{0,    0,    0, 0, 0, 0, 1};
    vt[1]  = '{1,    1,    0, 0, 0, 0, 1};
    vt[2]  = '{1203, 1203, 0, 0, 0, 0, 1};
    vt[3]  = '{1204, 1204, 0, 1, 0, 0, 1};
    vt[4]  = '{1205, 1205, 0, 0, 0, 0, 1};
    vt[5]  = '{1220, 1220, 0, 0, 1, 0, 1};
    vt[6]  = '{1251, 1251, 0, 0, 0, 0, 1};
    vt[7]  = '{1252, 1252, 0, 0, 0, 0, 0};
    vt[8]  = '{1434, 1434, 0, 0, 0, 0, 0};
    vt[9]  = '{1435, 1435, 0, 0, 0, 0, 1};
    vt[10] = '{1524, 1524, 0, 0, 0, 1, 1};
    vt[11] = '{1525, 0,    1, 0, 0, 0, 1};

    rst0 = 1'b1; rst1 = 1'b1; ce0 = 1'b0; ce1 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t_m[k] = 0; ehs[k] = 1'b1; evs[k] = 1'b1; ede[k] = 1'b0;
    end
    @(negedge clk);
    cyc(0, 0);
    cyc(1, 1);
    cyc(1, 1);
    chk("rst_h_count", 64'(o0.h), 64'd0);
    chk("rst_hsync", 64'(o0.hs), 64'd1);
    chk("rst_de", 64'(o0.de), 64'd0);
    chk("rst_strobes_with_ce", 64'({o0.pre, o0.hbs, o0.le, o0.fe}), 64'd0);

    // Free-running first line and the start of the second.
    rst0 = 1'b0; rst1 = 1'b0;
    hs_low = 0;
    last_t0 = -1;
    for (int i = 0; i < 12; i++) begin
      for (int n = 0; n < 3000 && last_t0 < vt[i].t; n++) cyc(1, 0);
      chk($sformatf("vec%0d_h", i), 64'(last0.h), 64'(vt[i].h));
      chk($sformatf("vec%0d_v", i), 64'(last0.v), 64'(vt[i].v));
      chk($sformatf("vec%0d_pre", i), 64'(last0.pre), 64'(vt[i].pre));
      chk($sformatf("vec%0d_hbs", i), 64'(last0.hbs), 64'(vt[i].hbs));
      chk($sformatf("vec%0d_le", i), 64'(last0.le), 64'(vt[i].le));
      chk($sformatf("vec%0d_hsync", i), 64'(last0.hs), 64'(vt[i].hs));
    end
    chk("hsync_low_clocks", 64'(hs_low), 64'd183);

    // Half-rate pixel enable: a line spans twice as many clocks.
    for (int n = 0; n < 2000 && t_m[0] < 3050; n++) cyc(1, 0);
    le_at.delete();
    bad_strobe = 0;
    for (int n = 0; n < 8000 && le_at.size() < 2; n++) cyc((n % 2) == 0, 0);
    chk("alt_ce_line_ends", 64'(le_at.size()), 64'd2);
    if (le_at.size() >= 2) chk("alt_ce_line_clocks", 64'(le_at[1] - le_at[0]), 64'd3050);
    chk("strobe_while_ce_low", 64'(bad_strobe), 64'd0);

    for (int n = 0; n < 3000; n++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset inside the hsync pulse so its return to 1 is observable.
    for (int n = 0; n < 2000 && (t_m[0] % 1525) != 1300; n++) cyc(1, 0);
    chk("pre_rst_hsync_low", 64'(o0.hs), 64'd0);
    rst0 = 1'b1;
    #1;
    chk("async_rst_h", 64'(o0.h), 64'd0);
    chk("async_rst_v", 64'(o0.v), 64'd0);
    chk("async_rst_hsync", 64'(o0.hs), 64'd1);
    chk("async_rst_strobes", 64'({o0.pre, o0.hbs, o0.le, o0.fe}), 64'd0);
    @(negedge clk);
    for (int n = 0; n < 3; n++) cyc(1, 0);
    rst0 = 1'b0;
    cyc(1, 0);
    chk("post_rst_h_is_1", 64'(o0.h), 64'd1);
    cyc(1, 0);
    chk("post_rst_h_is_2", 64'(o0.h), 64'd2);

    // Tiny raster: 2048 frames of 32 clocks to see the frame counter roll over.
    rst1 = 1'b1;
    cyc(0, 1);
    cyc(0, 1);
    rst1 = 1'b0;
    fe_cnt = 0;
    for (int n = 0; n < 70000 && t_m[1] < 65535; n++) cyc(0, 1);
    chk("frame_before_wrap", 64'(o1.f), 64'd2047);
    chk("frame_end_at_last", 64'(o1.fe), 64'd1);
    chk("frame_ends_before_wrap", 64'(fe_cnt), 64'd2047);
    cyc(0, 1);
    chk("frame_after_wrap", 64'(o1.f), 64'd0);
    chk("frame_ends_total", 64'(fe_cnt), 64'd2048);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
